can_bit_timing: RTL and testbench

- Runtime-configurable CAN bit-timing / bit-level engine: a successor to the fixed-parameter bit-level block.
- Divides clk into time quanta (tq) through a baud-rate prescaler and segments each bit into SYNC / TSEG1 / TSEG2.
- Performs hard sync and SJW-limited resynchronisation, samples rx, and drives tx.
- Sits between the CAN PHY pins and the frame-level controller, using the same req/rbit/tbit handshake.

---
 rtl/can_bit_timing.sv | 239 +++++++++++++++++++++++
 tb/tb_can_bit_timing.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/can_bit_timing.sv
// CAN bit-timing engine: tq prescaler, SYNC/SEG1/SEG2 sequencing, hard sync and SJW resync.
// Optional CAN_TRIPLE_SAMPLE_EN: majority vote over the last three SEG1 tq instead of a single sample.
module can_bit_timing #(
  parameter int unsigned BRP_W     = 8,
  parameter int unsigned TSEG1_W   = 4,
  parameter int unsigned TSEG2_W   = 3,
  parameter int unsigned SJW_W     = 2,
  parameter int unsigned IDLE_BITS = 11
) (
  input  logic               rstn,
  input  logic               clk,
  input  logic               can_rx,
  output logic               can_tx,
  input  logic [BRP_W-1:0]   cfg_brp,
  input  logic [TSEG1_W-1:0] cfg_tseg1,
  input  logic [TSEG2_W-1:0] cfg_tseg2,
  input  logic [SJW_W-1:0]   cfg_sjw,
  output logic               req,
  output logic               rbit,
  input  logic               tbit,
  output logic               bus_idle,
  output logic [7:0]         resync_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_SEG1, ST_SEG2} state_e;

  state_e             state_q, state_d;
  logic               sync1_q, sync2_q, rx_q, rx_prev_q;
  logic [BRP_W-1:0]   brp_q, psc_q, psc_d;
  logic [TSEG1_W-1:0] tseg1_q;
  logic [TSEG2_W-1:0] tseg2_q;
  logic [SJW_W-1:0]   sjw_q;
  logic [4:0]         tq_cnt_q, tq_cnt_d, seg1_len_q, seg1_len_d, seg2_len_q, seg2_len_d;
  logic               skip_q, skip_d, used_q, used_d, idle_q, idle_d;
  logic               rbit_q, rbit_d, tx_q, tx_d;
  logic [3:0]         idle_cnt_q, idle_cnt_d;
  logic [7:0]         rcnt_q, rcnt_d;

  logic       fall, tq_tick, hard_sync, resync_ok, early_short, skip_eff;
  logic       seg1_last, seg2_last, sample, sample_val;
  logic [4:0] tseg1_len, tseg2_len, sjw_len, sjw_eff, lengthen, rem;
  logic [4:0] seg1_len_eff, seg2_len_eff;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_q      <= 1'b1;
      rx_prev_q <= 1'b1;
      brp_q     <= '0;
      tseg1_q   <= '0;
      tseg2_q   <= '0;
      sjw_q     <= '0;
    end else begin
      sync1_q   <= can_rx;
      sync2_q   <= sync1_q;
      rx_q      <= sync2_q;
      rx_prev_q <= rx_q;
      if (idle_q) begin
        brp_q   <= cfg_brp;
        tseg1_q <= cfg_tseg1;
        tseg2_q <= cfg_tseg2;
        sjw_q   <= cfg_sjw;
      end
    end
  end

  always_comb begin
    fall      = rx_prev_q & ~rx_q;
    tq_tick   = (psc_q == brp_q);
    hard_sync = fall & ((state_q == ST_IDLE) | idle_q);
    tseg1_len = 5'(tseg1_q) + 5'd1;
    tseg2_len = 5'(tseg2_q) + 5'd1;
    sjw_len   = 5'(sjw_q) + 5'd1;
    sjw_eff   = (sjw_len < tseg2_len) ? sjw_len : tseg2_len;
    resync_ok = fall & ~idle_q & tbit & ~used_q & ~hard_sync &
                ((state_q == ST_SEG1) | (state_q == ST_SEG2));
    lengthen  = ((tq_cnt_q + 5'd1) < sjw_eff) ? (tq_cnt_q + 5'd1) : sjw_eff;
    rem       = seg2_len_q - tq_cnt_q;
    // Segment lengths are adjusted in the edge clk itself so an edge on the final tick is honoured.
    seg1_len_eff = (resync_ok && state_q == ST_SEG1) ? seg1_len_q + lengthen : seg1_len_q;
    early_short  = resync_ok && (state_q == ST_SEG2) && (rem <= sjw_eff);
    seg2_len_eff = seg2_len_q;
    if (resync_ok && state_q == ST_SEG2)
      seg2_len_eff = early_short ? tq_cnt_q + 5'd1 : seg2_len_q - sjw_eff;
    skip_eff  = skip_q | early_short;
    seg1_last = (state_q == ST_SEG1) && tq_tick && (tq_cnt_q == seg1_len_eff - 5'd1);
    seg2_last = (state_q == ST_SEG2) && tq_tick && (tq_cnt_q == seg2_len_eff - 5'd1);
    sample    = seg1_last & ~hard_sync;
  end

  always_comb begin
    state_d    = state_q;
    psc_d      = tq_tick ? '0 : psc_q + BRP_W'(1);
    tq_cnt_d   = tq_cnt_q;
    seg1_len_d = seg1_len_q;
    seg2_len_d = seg2_len_q;
    skip_d     = skip_q;
    used_d     = used_q;
    idle_d     = idle_q;
    rbit_d     = rbit_q;
    tx_d       = tx_q;
    idle_cnt_d = idle_cnt_q;
    rcnt_d     = rcnt_q;
    if (hard_sync) begin
      psc_d      = '0;
      state_d    = ST_SEG1;
      tq_cnt_d   = '0;
      seg1_len_d = tseg1_len;
      used_d     = 1'b0;
      skip_d     = 1'b0;
      idle_d     = 1'b0;
      idle_cnt_d = '0;
    end else begin
      if (resync_ok) begin
        used_d     = 1'b1;
        rcnt_d     = (rcnt_q == 8'hFF) ? rcnt_q : rcnt_q + 8'd1;
        seg1_len_d = seg1_len_eff;
        seg2_len_d = seg2_len_eff;
        skip_d     = skip_eff;
      end
      case (state_q)
        ST_SYNC: if (tq_tick) begin
          state_d    = ST_SEG1;
          tq_cnt_d   = '0;
          seg1_len_d = tseg1_len;
        end
        ST_SEG1: if (tq_tick) begin
          if (seg1_last) begin
            state_d    = ST_SEG2;
            tq_cnt_d   = '0;
            seg2_len_d = tseg2_len;
            skip_d     = 1'b0;
            used_d     = 1'b0;
            rbit_d     = sample_val;
            idle_cnt_d = rx_q ? ((idle_cnt_q == 4'hF) ? idle_cnt_q : idle_cnt_q + 4'd1) : '0;
          end else begin
            tq_cnt_d = tq_cnt_q + 5'd1;
          end
        end
        ST_SEG2: if (tq_tick) begin
          if (seg2_last) begin
            tx_d     = tbit;
            tq_cnt_d = '0;
            skip_d   = 1'b0;
            // An early edge within SJW turns the current tq into the next bit's SYNC.
            if (idle_cnt_q >= 4'(IDLE_BITS)) begin
              state_d = ST_IDLE;
              idle_d  = 1'b1;
            end else if (skip_eff) begin
              state_d    = ST_SEG1;
              seg1_len_d = tseg1_len;
            end else begin
              state_d = ST_SYNC;
            end
          end else begin
            tq_cnt_d = tq_cnt_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      psc_q      <= '0;
      tq_cnt_q   <= '0;
      seg1_len_q <= '0;
      seg2_len_q <= '0;
      skip_q     <= 1'b0;
      used_q     <= 1'b0;
      idle_q     <= 1'b1;
      rbit_q     <= 1'b1;
      tx_q       <= 1'b1;
      idle_cnt_q <= '0;
      rcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      psc_q      <= psc_d;
      tq_cnt_q   <= tq_cnt_d;
      seg1_len_q <= seg1_len_d;
      seg2_len_q <= seg2_len_d;
      skip_q     <= skip_d;
      used_q     <= used_d;
      idle_q     <= idle_d;
      rbit_q     <= rbit_d;
      tx_q       <= tx_d;
      idle_cnt_q <= idle_cnt_d;
      rcnt_q     <= rcnt_d;
    end
  end

`ifdef CAN_TRIPLE_SAMPLE_EN
  logic [1:0] cap_q, cap_d, capv_q, capv_d;
  logic       vote_a, vote_b, capture, seg1_entry;

  // Captures missing because SEG1 is shorter than 3 tq fall back to the sample-clk value.
  always_comb begin
    vote_a     = capv_q[1] ? cap_q[1] : rx_q;
    vote_b     = capv_q[0] ? cap_q[0] : rx_q;
    sample_val = (vote_a & vote_b) | (vote_a & rx_q) | (vote_b & rx_q);
  end

  always_comb begin
    seg1_entry = (state_d == ST_SEG1) && (state_q != ST_SEG1);
    capture    = (state_q == ST_SEG1) && tq_tick && !seg1_last &&
                 ((tq_cnt_q + 5'd3) >= seg1_len_eff);
    cap_d      = cap_q;
    capv_d     = capv_q;
    if (seg1_entry) begin
      capv_d = '0;
    end else if (capture) begin
      cap_d  = {cap_q[0], rx_q};
      capv_d = {capv_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_q  <= '1;
      capv_q <= '0;
    end else begin
      cap_q  <= cap_d;
      capv_q <= capv_d;
    end
  end
`else
  always_comb sample_val = rx_q;
`endif

  assign can_tx     = tx_q;
  assign req        = sample;
  assign rbit       = sample ? sample_val : rbit_q;
  assign bus_idle   = idle_q;
  assign resync_cnt = rcnt_q;

endmodule

// File: tb/tb_can_bit_timing.sv
// Self-checking bench for can_bit_timing: scoreboard of expected req cycles and sampled bits.
module tb_can_bit_timing;

  logic       clk = 1'b0;
  logic       rstn, can_rx, can_tx, tbit, req, rbit, bus_idle;
  logic [7:0] cfg_brp;
  logic [3:0] cfg_tseg1;
  logic [2:0] cfg_tseg2;
  logic [1:0] cfg_sjw;
  logic [7:0] resync_cnt;

  can_bit_timing #(
    .BRP_W(8), .TSEG1_W(4), .TSEG2_W(3), .SJW_W(2), .IDLE_BITS(11)
  ) dut (
    .rstn(rstn), .clk(clk), .can_rx(can_rx), .can_tx(can_tx),
    .cfg_brp(cfg_brp), .cfg_tseg1(cfg_tseg1), .cfg_tseg2(cfg_tseg2), .cfg_sjw(cfg_sjw),
    .req(req), .rbit(rbit), .tbit(tbit), .bus_idle(bus_idle), .resync_cnt(resync_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct { int cyc; logic rbit; } exp_t;
  exp_t sb[$];

`ifdef CAN_TRIPLE_SAMPLE_EN
  localparam logic GLITCH_RBIT = 1'b1;
`else
  localparam logic GLITCH_RBIT = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic b);
    sb.push_back('{cyc: c, rbit: b});
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn === 1'b1) begin
      if (req === 1'b1) begin
        if (sb.size() == 0) begin
          check("req_unexpected", {31'b0, req}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("req_cycle", cyc, e.cyc);
          check("rbit", {31'b0, rbit}, {31'b0, e.rbit});
        end
      end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
        check("req_missing", {31'b0, req}, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, s, r, q, c1, c2;
    rstn = 1'b0; can_rx = 1'b1; tbit = 1'b1;
    cfg_brp = 8'd1; cfg_tseg1 = 4'd4; cfg_tseg2 = 3'd3; cfg_sjw = 2'd1;
    repeat (3) @(negedge clk);
    check("rst_can_tx", can_tx, 1); check("rst_req", req, 0); check("rst_rbit", rbit, 1);
    check("rst_bus_idle", bus_idle, 1); check("rst_resync_cnt", resync_cnt, 0);
    rstn = 1'b1;

    // Recessive bus: no sample points, stays idle.
    goto(cyc + 500);
    check("idle_bus_idle", bus_idle, 1); check("idle_can_tx", can_tx, 1);
    check("idle_resync_cnt", resync_cnt, 0);

    // Hard sync: first req 10 clk after the hard-sync clk (pin + 3), then every 20.
    c0 = cyc + 2;
    push(c0 + 13, 1'b0); push(c0 + 33, 1'b1);
    goto(c0); can_rx = 1'b0;
    goto(c0 + 13); check("hs_bus_idle", bus_idle, 0);
    goto(c0 + 20); can_rx = 1'b1;

    // Late edge at SEG1 tq 2 of bit 2: +2 tq, second edge in the same bit ignored.
    s = c0 + 44;
    push(s + 13, 1'b0); push(s + 33, 1'b1);
    goto(s + 1); can_rx = 1'b0;
    goto(s + 3); can_rx = 1'b1;
    goto(s + 5); can_rx = 1'b0;
    goto(s + 13); check("late_resync_cnt", resync_cnt, 1);
    goto(s + 15); can_rx = 1'b1;
    goto(s + 33); check("late_second_ignored", resync_cnt, 1);

    // Early edge with 1 tq of SEG2 left: bit shortened to 18 clk.
    r = s + 33;
    push(r + 18, 1'b0); push(r + 38, 1'b1);
    goto(r + 4); can_rx = 1'b0;
    goto(r + 18); check("early_resync_cnt", resync_cnt, 2);
    goto(r + 20); can_rx = 1'b1;
    goto(r + 22); tbit = 1'b0;

    // Same early edge while transmitting dominant: no adjustment.
    q = r + 38;
    push(q + 20, 1'b0);
    goto(q + 4); can_rx = 1'b0;
    goto(q + 20);
    check("tx0_can_tx", can_tx, 0); check("tx0_resync_cnt", resync_cnt, 2);
    can_rx = 1'b1; tbit = 1'b1;

    // Eleven recessive samples end the frame.
    for (int k = 1; k <= 11; k++) push(q + 20 + 20 * k, 1'b1);
    goto(q + 248); check("idle_before", bus_idle, 0);
    goto(q + 249); check("idle_after", bus_idle, 1); check("idle_tx", can_tx, 1);
    goto(q + 300); check("sb_drain1", sb.size(), 0);

    // Glitch at the sample point, then reset in SEG2.
    tbit = 1'b0;
    c1 = cyc + 2;
    push(c1 + 13, 1'b0); push(c1 + 33, GLITCH_RBIT);
    goto(c1); can_rx = 1'b0;
    goto(c1 + 20); can_rx = 1'b1;
    goto(c1 + 29); can_rx = 1'b0;
    goto(c1 + 31); can_rx = 1'b1;
    goto(c1 + 37);
    check("pre_rst_can_tx", can_tx, 0); check("pre_rst_bus_idle", bus_idle, 0);
    check("pre_rst_resync_cnt", resync_cnt, 2);
    rstn = 1'b0;
    #1;
    check("mid_rst_can_tx", can_tx, 1); check("mid_rst_req", req, 0);
    check("mid_rst_rbit", rbit, 1); check("mid_rst_bus_idle", bus_idle, 1);
    check("mid_rst_resync_cnt", resync_cnt, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1; tbit = 1'b1;

    // First fall after reset hard-syncs again.
    c2 = cyc + 5;
    push(c2 + 13, 1'b0);
    for (int k = 0; k <= 10; k++) push(c2 + 33 + 20 * k, 1'b1);
    goto(c2); can_rx = 1'b0;
    goto(c2 + 20); can_rx = 1'b1;
    goto(c2 + 242); check("post_rst_idle", bus_idle, 1);
    goto(c2 + 262); check("sb_drain2", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
